// File: rtl/mem_issue_queue_pkg.sv
// Micro-op types shared with the decoder, plus a small helper used by the
// memory issue queue to recognise the opcodes it is meant to carry.
package DecoderTypes;

    typedef enum logic [7:0] {
        m_nop     = 8'h00,
        m_ld      = 8'h10,
        m_st      = 8'h11,
        m_clflush = 8'h12,
        m_alu     = 8'h20
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [31:0] src0_val;
        logic [31:0] src1_val;
        logic [5:0]  rob_idx;
    } micro_op_t;

endpackage

package mem_issue_queue_pkg;

    import DecoderTypes::*;

    // True for the three opcodes the memory pipeline understands.
    function automatic logic is_mem_op(input opcode_t op);
        return (op == m_ld) || (op == m_st) || (op == m_clflush);
    endfunction

endpackage

// File: rtl/mem_issue_queue_ring_buffer.sv
// mop_ring_buffer: circular micro-op storage with head/tail/count tracking.
// The caller guarantees push only when not full and pop only when not empty.
module mop_ring_buffer
    import DecoderTypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  micro_op_t                  push_data,
    input  logic                       pop,
    output micro_op_t                  head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    micro_op_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers and occupancy; pointers wrap by natural overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset clears pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order buffer feeding the memory pipeline. Ops from
// dispatch are held and issued one per cycle while the pipeline is idle.
// Optional macro MEM_ISSUE_BYPASS_EN lets an op arriving at an empty queue
// issue in the same cycle without being stored.
module mem_issue_queue
    import DecoderTypes::*;
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       enq_valid,
    input  micro_op_t                  enq_mop,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       mp_busy,
    output logic                       out_ready,
    output micro_op_t                  out_mop
);

    micro_op_t head_data;
    logic      buf_full;
    logic      buf_empty;
    logic      push;
    logic      pop;
    logic      bypass;

    // Issue and enqueue decisions; reset overrides everything, then squash.
    always_comb begin
        bypass    = 1'b0;
`ifdef MEM_ISSUE_BYPASS_EN
        bypass    = reset && buf_empty && enq_valid && !mp_busy && !squash;
`endif
        pop       = reset && !buf_empty && !mp_busy && !squash;
        push      = reset && enq_valid && !buf_full && !squash && !bypass;
        out_ready = pop || bypass;
        out_mop   = bypass ? enq_mop : head_data;
    end

    mop_ring_buffer #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (squash),
        .push      (push),
        .push_data (enq_mop),
        .pop       (pop),
        .head_data (head_data),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (count)
    );

    assign full = buf_full;

    // Flag non-memory opcodes at acceptance; they are still carried through.
    always_ff @(posedge clk) begin
        if (push || bypass) begin
            assert (is_mem_op(enq_mop.opcode))
            else $error("mem_issue_queue: non-memory opcode %0h accepted", enq_mop.opcode);
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_mem_issue_queue;
    import DecoderTypes::*;

    localparam int DEPTH = 4;
`ifdef MEM_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       squash;
    logic       enq_valid;
    micro_op_t  enq_mop;
    logic       full;
    logic [2:0] count;
    logic       mp_busy;
    logic       out_ready;
    micro_op_t  out_mop;

    int vectors = 0;
    int miscompares = 0;
    micro_op_t model_q[$];
    micro_op_t last_issued;

    mem_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .squash    (squash),
        .enq_valid (enq_valid),
        .enq_mop   (enq_mop),
        .full      (full),
        .count     (count),
        .mp_busy   (mp_busy),
        .out_ready (out_ready),
        .out_mop   (out_mop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic micro_op_t mk(input opcode_t op, input logic [31:0] s0);
        micro_op_t m;
        m.opcode   = op;
        m.src0_val = s0;
        m.src1_val = $urandom;
        m.rob_idx  = 6'($urandom);
        return m;
    endfunction

    // One clock cycle: drive, check outputs at the falling edge, then advance
    // the model across the rising edge.
    task automatic cyc(input logic ev, input micro_op_t m, input logic busy,
                       input logic sq, input logic rn, input bit do_chk);
        int  sz;
        bit  byp;
        bit  exp_ready;
        enq_valid = ev;
        enq_mop   = m;
        mp_busy   = busy;
        squash    = sq;
        reset     = rn;
        #4;
        sz        = model_q.size();
        byp       = BYP && rn && ev && !busy && !sq && (sz == 0);
        exp_ready = rn && !sq && !busy && ((sz != 0) || byp);
        if (do_chk) begin
            chk("count", 128'(count), 128'(sz));
            chk("full", 128'(full), 128'(sz == DEPTH));
            chk("out_ready", 128'(out_ready), 128'(exp_ready));
            if (exp_ready)
                chk("out_mop", 128'(out_mop), 128'((sz != 0) ? model_q[0] : m));
        end
        if (rn && ev && !sq && sz == DEPTH)
            $display("note: enq_valid while full at %0t, dispatch must hold the op", $time);
        @(posedge clk);
        if (!rn || sq) begin
            model_q.delete();
        end else begin
            if (exp_ready) last_issued = (sz != 0) ? model_q[0] : m;
            if (sz != 0 && !busy) void'(model_q.pop_front());
            if (ev && sz < DEPTH && !byp) model_q.push_back(m);
        end
        #1;
    endtask

    micro_op_t nop_op;
    micro_op_t a_op, b_op, c_op;

    initial begin
        nop_op    = mk(m_nop, 32'h0);
        reset     = 1'b0;
        squash    = 1'b0;
        enq_valid = 1'b0;
        enq_mop   = nop_op;
        mp_busy   = 1'b0;

        // Reset, then reset-state checks.
        cyc(0, nop_op, 0, 0, 0, 0);
        cyc(0, nop_op, 0, 0, 0, 1);
        cyc(0, nop_op, 0, 0, 1, 1);

        // Single load, minimum latency.
        a_op = mk(m_ld, 32'h1000);
        cyc(1, a_op, 0, 0, 1, 1);
        cyc(0, nop_op, 0, 0, 1, 1);
        chk("first_src0", 128'(last_issued.src0_val), 128'(32'h1000));

        // Fill while busy, fifth enqueue dropped.
        for (int i = 0; i < 5; i++) cyc(1, mk(m_st, 32'h2000 + i), 1, 0, 1, 1);
        cyc(0, nop_op, 1, 0, 1, 1);
        chk("full_count", 128'(count), 128'(3'd4));
        for (int i = 0; i < 4; i++) begin
            cyc(0, nop_op, 0, 0, 1, 1);
            cyc(0, nop_op, 1, 0, 1, 1);
        end

        // FIFO order across op types with single-cycle releases.
        a_op = mk(m_ld, 32'hA);
        b_op = mk(m_st, 32'hB);
        c_op = mk(m_clflush, 32'hC);
        cyc(1, a_op, 1, 0, 1, 1);
        cyc(1, b_op, 1, 0, 1, 1);
        cyc(1, c_op, 1, 0, 1, 1);
        cyc(0, nop_op, 0, 0, 1, 1);
        chk("order_a", 128'(last_issued.src0_val), 128'(32'hA));
        cyc(0, nop_op, 1, 0, 1, 1);
        cyc(0, nop_op, 0, 0, 1, 1);
        chk("order_b", 128'(last_issued.src0_val), 128'(32'hB));
        cyc(0, nop_op, 1, 0, 1, 1);
        cyc(0, nop_op, 0, 0, 1, 1);
        chk("order_c", 128'(last_issued.src0_val), 128'(32'hC));
        cyc(0, nop_op, 1, 0, 1, 1);

        // Count 2 with simultaneous enqueue and issue.
        cyc(1, mk(m_ld, 32'h31), 1, 0, 1, 1);
        cyc(1, mk(m_ld, 32'h32), 1, 0, 1, 1);
        cyc(1, mk(m_st, 32'h33), 0, 0, 1, 1);
        chk("simul_head", 128'(last_issued.src0_val), 128'(32'h31));
        cyc(0, nop_op, 1, 0, 1, 1);

        // Count 3 then squash with an enqueue.
        cyc(1, mk(m_ld, 32'h41), 1, 0, 1, 1);
        cyc(1, nop_op, 0, 1, 1, 1);
        cyc(0, nop_op, 0, 0, 1, 1);

        // Count 3 then reset.
        for (int i = 0; i < 3; i++) cyc(1, mk(m_st, 32'h50 + i), 1, 0, 1, 1);
        cyc(0, nop_op, 0, 0, 0, 1);
        cyc(0, nop_op, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            opcode_t op;
            case ($urandom_range(2))
                0:       op = m_ld;
                1:       op = m_st;
                default: op = m_clflush;
            endcase
            cyc(($urandom_range(99) < 60), mk(op, $urandom), ($urandom_range(99) < 50),
                ($urandom_range(99) < 3), ($urandom_range(99) >= 2), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
